// File: rtl/mesh_l2_arbiter_if.sv
// mesh_l2_arbiter_if
// Bundles the tile request/response buses and the shared L2 port of the
// mesh L2 arbiter.
//   slave  : arbiter side (tile requests and L2 responses in; L2 beats and routed responses out)
//   master : environment side (drives tiles and the L2 model)
// Optional: MESH_L2_ARB_PERF_EN adds stall_cnt_o (N_REQ x 32 per-tile stall counters).
interface mesh_l2_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [N_REQ-1:0]             req_valid_i;
   logic [N_REQ-1:0]             req_ready_o;
   logic [N_REQ-1:0][ADDR_W-1:0] req_addr_i;
   logic [N_REQ-1:0]             req_we_i;
   logic [N_REQ-1:0][DATA_W-1:0] req_wdata_i;
   logic [N_REQ-1:0]             req_last_i;
   logic                         l2_valid_o;
   logic                         l2_ready_i;
   logic [ADDR_W-1:0]            l2_addr_o;
   logic                         l2_we_o;
   logic [DATA_W-1:0]            l2_wdata_o;
   logic                         l2_rsp_valid_i;
   logic [DATA_W-1:0]            l2_rsp_rdata_i;
   logic [N_REQ-1:0]             rsp_valid_o;
   logic [DATA_W-1:0]            rsp_rdata_o;
   logic                         rsp_err_o;
`ifdef MESH_L2_ARB_PERF_EN
   logic [N_REQ-1:0][31:0]       stall_cnt_o;
`endif

   modport slave (
      input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_last_i,
      input  l2_ready_i, l2_rsp_valid_i, l2_rsp_rdata_i,
      output req_ready_o, l2_valid_o, l2_addr_o, l2_we_o, l2_wdata_o,
      output rsp_valid_o, rsp_rdata_o, rsp_err_o
`ifdef MESH_L2_ARB_PERF_EN
      , output stall_cnt_o
`endif
   );

   modport master (
      output req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_last_i,
      output l2_ready_i, l2_rsp_valid_i, l2_rsp_rdata_i,
      input  req_ready_o, l2_valid_o, l2_addr_o, l2_we_o, l2_wdata_o,
      input  rsp_valid_o, rsp_rdata_o, rsp_err_o
`ifdef MESH_L2_ARB_PERF_EN
      , input stall_cnt_o
`endif
   );
endinterface

// File: rtl/mesh_l2_arbiter.sv
// mesh_l2_arbiter
// Round-robin arbiter of N_REQ tiles onto one L2 port. Bursts lock the
// grant to their owner until the last beat. The request path is purely
// combinational. Every accepted beat pushes its tile index into an in-order
// FIFO so that L2 responses can be routed back one-hot.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   bus    : mesh_l2_arbiter_if.slave (tile requests, L2 port, routed responses)
// Optional: MESH_L2_ARB_PERF_EN adds per-tile saturating stall counters
//           (cycles with valid high and ready low) on bus.stall_cnt_o.
module mesh_l2_arbiter #(
   parameter int N_REQ     = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_OUTST = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   mesh_l2_arbiter_if.slave  bus
);
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int CNT_W = $clog2(MAX_OUTST + 1);

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t           r_state, w_state_nxt;
   logic [IDX_W-1:0] r_rr_ptr, w_rr_nxt;
   logic [IDX_W-1:0] r_owner, w_owner_nxt;

   logic [IDX_W-1:0] r_fifo [MAX_OUTST];
   logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_err;

   logic [IDX_W-1:0] w_scan_idx, w_rr_idx, w_gnt, w_gnt_inc;
   logic             w_rr_any, w_gnt_any, w_gnt_vld;
   logic             w_full, w_empty, w_acc, w_pop;

   assign w_full  = (r_count == CNT_W'(MAX_OUTST));
   assign w_empty = (r_count == '0);

   // First valid tile at or after rr_ptr: scan downward so the smallest
   // offset is the last (winning) assignment.
   always_comb begin
      w_rr_any   = 1'b0;
      w_rr_idx   = r_rr_ptr;
      w_scan_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         w_scan_idx = IDX_W'((int'(r_rr_ptr) + i) % N_REQ);
         if (bus.req_valid_i[w_scan_idx]) begin
            w_rr_any = 1'b1;
            w_rr_idx = w_scan_idx;
         end
      end
   end

   // While locked the owner stays the grantee even with its valid low, so
   // other tiles cannot slip into the middle of a burst.
   always_comb begin
      if (r_state == S_LOCKED) begin
         w_gnt     = r_owner;
         w_gnt_any = 1'b1;
         w_gnt_vld = bus.req_valid_i[r_owner];
      end else begin
         w_gnt     = w_rr_idx;
         w_gnt_any = w_rr_any;
         w_gnt_vld = w_rr_any;
      end
   end

   assign w_gnt_inc      = (w_gnt == IDX_W'(N_REQ - 1)) ? '0 : w_gnt + 1'b1;
   assign bus.l2_valid_o = w_gnt_vld & ~w_full & ~rst_i;
   assign bus.l2_addr_o  = bus.req_addr_i[w_gnt];
   assign bus.l2_we_o    = bus.req_we_i[w_gnt];
   assign bus.l2_wdata_o = bus.req_wdata_i[w_gnt];
   assign w_acc          = bus.l2_valid_o & bus.l2_ready_i;

   always_comb begin
      bus.req_ready_o = '0;
      if (w_gnt_any && !rst_i)
         bus.req_ready_o[w_gnt] = bus.l2_ready_i & ~w_full;
   end

   // FSM
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= '0;
         r_owner  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_rr_ptr <= w_rr_nxt;
         r_owner  <= w_owner_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rr_nxt    = r_rr_ptr;
      w_owner_nxt = r_owner;
      case (r_state)
         S_IDLE: begin
            if (w_acc) begin
               if (bus.req_last_i[w_gnt]) begin
                  w_rr_nxt = w_gnt_inc;
               end else begin
                  w_owner_nxt = w_gnt;
                  w_state_nxt = S_LOCKED;
               end
            end
         end
         S_LOCKED: begin
            if (w_acc && bus.req_last_i[w_gnt]) begin
               w_rr_nxt    = w_gnt_inc;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Response routing FIFO. A push is only possible when not full because
   // l2_valid_o is already gated by w_full, even if a pop happens this cycle.
   assign w_pop = bus.l2_rsp_valid_i & ~w_empty;

   always_ff @(posedge clk_i) begin
      if (w_acc)
         r_fifo[r_wr_ptr] <= w_gnt;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_acc)
            r_wr_ptr <= (r_wr_ptr == PTR_W'(MAX_OUTST - 1)) ? '0 : r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= (r_rd_ptr == PTR_W'(MAX_OUTST - 1)) ? '0 : r_rd_ptr + 1'b1;
         case ({w_acc, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (bus.l2_rsp_valid_i && w_empty)
            r_err <= 1'b1;
      end
   end

   always_comb begin
      bus.rsp_valid_o = '0;
      if (w_pop)
         bus.rsp_valid_o[r_fifo[r_rd_ptr]] = 1'b1;
   end

   assign bus.rsp_rdata_o = bus.l2_rsp_rdata_i;
   assign bus.rsp_err_o   = r_err;

`ifdef MESH_L2_ARB_PERF_EN
   logic [N_REQ-1:0][31:0] r_stall_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_stall_cnt <= '0;
      end else begin
         for (int k = 0; k < N_REQ; k++) begin
            if (bus.req_valid_i[k] && !bus.req_ready_o[k] && (r_stall_cnt[k] != 32'hFFFF_FFFF))
               r_stall_cnt[k] <= r_stall_cnt[k] + 32'd1;
         end
      end
   end

   assign bus.stall_cnt_o = r_stall_cnt;
`endif
endmodule

// File: tb/tb_mesh_l2_arbiter.sv
// Directed bench for mesh_l2_arbiter: reset, round-robin, burst lock,
// FIFO full back-pressure, response routing, reset mid-burst and the
// optional stall counters.
module tb_mesh_l2_arbiter;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mesh_l2_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   mesh_l2_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   // Tile k presents address 0x1000+k so the grantee shows on l2_addr_o.
   task automatic idle_inputs();
      bus.req_valid_i    = '0;
      bus.req_we_i       = '0;
      bus.req_last_i     = '0;
      bus.l2_ready_i     = 1'b0;
      bus.l2_rsp_valid_i = 1'b0;
      bus.l2_rsp_rdata_i = '0;
      for (int k = 0; k < N; k++) begin
         bus.req_addr_i[k]  = 32'h1000 + k;
         bus.req_wdata_i[k] = 32'hD000 + k;
      end
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.req_valid_i    = 4'hF;
      bus.req_last_i     = 4'hF;
      bus.l2_ready_i     = 1'b1;
      bus.l2_rsp_valid_i = 1'b1;
      #3;
      n_chk++; if (bus.l2_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_l2_valid got=%b exp=0", bus.l2_valid_o); end
      n_chk++; if (bus.req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready got=%b exp=0000", bus.req_ready_o); end
      n_chk++; if (bus.rsp_valid_o !== 4'b0000) begin n_fail++; $display("FAIL rst_rsp_valid got=%b exp=0000", bus.rsp_valid_o); end
      step();
      step();
      n_chk++; if (bus.rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", bus.rsp_err_o); end
      idle_inputs();
      rst = 1'b0;
      bus.req_valid_i = 4'hF;
      settle();
      n_chk++; if (bus.l2_addr_o !== 32'h1000) begin n_fail++; $display("FAIL rst_rr_ptr_grant got=%h exp=00001000", bus.l2_addr_o); end
      n_chk++; if (bus.l2_valid_o !== 1'b1) begin n_fail++; $display("FAIL rst_l2_valid_after got=%b exp=1", bus.l2_valid_o); end
      idle_inputs();
   endtask

   task automatic test_rr_single();
      do_reset();
      bus.req_valid_i = 4'b0101;
      bus.req_last_i  = 4'b0101;
      bus.l2_ready_i  = 1'b1;
      settle();
      n_chk++; if (bus.req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL rr_c0_ready got=%b exp=0001", bus.req_ready_o); end
      n_chk++; if (bus.l2_addr_o !== 32'h1000) begin n_fail++; $display("FAIL rr_c0_addr got=%h exp=00001000", bus.l2_addr_o); end
      step();
      bus.req_valid_i = 4'b0100;
      settle();
      n_chk++; if (bus.req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL rr_c1_ready got=%b exp=0100", bus.req_ready_o); end
      n_chk++; if (bus.l2_addr_o !== 32'h1002) begin n_fail++; $display("FAIL rr_c1_addr got=%h exp=00001002", bus.l2_addr_o); end
      step();
      // all valid, not accepted: grantee reveals rr_ptr
      bus.req_valid_i = 4'hF;
      bus.req_last_i  = 4'h0;
      bus.l2_ready_i  = 1'b0;
      settle();
      n_chk++; if (bus.l2_addr_o !== 32'h1003) begin n_fail++; $display("FAIL rr_ptr_after got=%h exp=00001003", bus.l2_addr_o); end
      bus.req_valid_i    = 4'h0;
      bus.l2_rsp_valid_i = 1'b1;
      settle();
      n_chk++; if (bus.rsp_valid_o !== 4'b0001) begin n_fail++; $display("FAIL rr_rsp0 got=%b exp=0001", bus.rsp_valid_o); end
      step();
      settle();
      n_chk++; if (bus.rsp_valid_o !== 4'b0100) begin n_fail++; $display("FAIL rr_rsp1 got=%b exp=0100", bus.rsp_valid_o); end
      step();
      idle_inputs();
   endtask

   task automatic test_lock_burst();
      do_reset();
      bus.l2_ready_i     = 1'b1;
      bus.req_we_i       = 4'b0010;
      bus.req_valid_i    = 4'b1010;
      bus.req_wdata_i[1] = 32'hB000;
      settle();
      n_chk++; if (bus.req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL lock_b0_ready got=%b exp=0010", bus.req_ready_o); end
      n_chk++; if (bus.l2_wdata_o !== 32'hB000 || bus.l2_we_o !== 1'b1) begin n_fail++; $display("FAIL lock_b0_data got=%h/%b exp=0000b000/1", bus.l2_wdata_o, bus.l2_we_o); end
      step();
      bus.req_valid_i = 4'b1000;
      settle();
      n_chk++; if (bus.l2_valid_o !== 1'b0) begin n_fail++; $display("FAIL lock_drop_l2_valid got=%b exp=0", bus.l2_valid_o); end
      n_chk++; if (bus.req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL lock_drop_ready got=%b exp=0010", bus.req_ready_o); end
      step();
      bus.req_valid_i    = 4'b1010;
      bus.req_wdata_i[1] = 32'hB001;
      bus.l2_rsp_valid_i = 1'b1;
      settle();
      n_chk++; if (bus.req_ready_o !== 4'b0010 || bus.l2_wdata_o !== 32'hB001) begin n_fail++; $display("FAIL lock_b1 got=%b/%h exp=0010/0000b001", bus.req_ready_o, bus.l2_wdata_o); end
      n_chk++; if (bus.rsp_valid_o !== 4'b0010) begin n_fail++; $display("FAIL lock_b1_rsp got=%b exp=0010", bus.rsp_valid_o); end
      step();
      bus.req_wdata_i[1] = 32'hB002;
      settle();
      n_chk++; if (bus.req_ready_o !== 4'b0010 || bus.l2_wdata_o !== 32'hB002) begin n_fail++; $display("FAIL lock_b2 got=%b/%h exp=0010/0000b002", bus.req_ready_o, bus.l2_wdata_o); end
      step();
      bus.req_wdata_i[1] = 32'hB003;
      bus.req_last_i     = 4'b0010;
      settle();
      n_chk++; if (bus.req_ready_o !== 4'b0010 || bus.l2_wdata_o !== 32'hB003) begin n_fail++; $display("FAIL lock_b3 got=%b/%h exp=0010/0000b003", bus.req_ready_o, bus.l2_wdata_o); end
      step();
      bus.req_valid_i    = 4'hF;
      bus.req_last_i     = 4'h0;
      bus.l2_ready_i     = 1'b0;
      bus.l2_rsp_valid_i = 1'b0;
      settle();
      n_chk++; if (bus.l2_addr_o !== 32'h1002) begin n_fail++; $display("FAIL lock_rr_ptr got=%h exp=00001002", bus.l2_addr_o); end
      bus.req_valid_i    = 4'b1000;
      bus.req_last_i     = 4'b1000;
      bus.req_we_i       = 4'b0000;
      bus.l2_ready_i     = 1'b1;
      bus.l2_rsp_valid_i = 1'b1;
      settle();
      n_chk++; if (bus.req_ready_o !== 4'b1000 || bus.l2_addr_o !== 32'h1003) begin n_fail++; $display("FAIL lock_t3 got=%b/%h exp=1000/00001003", bus.req_ready_o, bus.l2_addr_o); end
      n_chk++; if (bus.rsp_valid_o !== 4'b0010) begin n_fail++; $display("FAIL lock_t3_rsp got=%b exp=0010", bus.rsp_valid_o); end
      step();
      bus.req_valid_i = 4'h0;
      settle();
      n_chk++; if (bus.rsp_valid_o !== 4'b1000) begin n_fail++; $display("FAIL lock_t3_rsp2 got=%b exp=1000", bus.rsp_valid_o); end
      step();
      idle_inputs();
   endtask

   task automatic test_fifo_full();
      do_reset();
      bus.req_valid_i = 4'b0001;
      bus.req_last_i  = 4'b0001;
      bus.l2_ready_i  = 1'b1;
      for (int i = 0; i < MO; i++) begin
         settle();
         n_chk++; if (bus.req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL full_fill%0d got=%b exp=0001", i, bus.req_ready_o); end
         step();
      end
      settle();
      n_chk++; if (bus.req_ready_o !== 4'b0000 || bus.l2_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_block got=%b/%b exp=0000/0", bus.req_ready_o, bus.l2_valid_o); end
      step();
      bus.l2_rsp_valid_i = 1'b1;
      bus.l2_rsp_rdata_i = 32'h77;
      settle();
      n_chk++; if (bus.rsp_valid_o !== 4'b0001 || bus.rsp_rdata_o !== 32'h77) begin n_fail++; $display("FAIL full_pop got=%b/%h exp=0001/00000077", bus.rsp_valid_o, bus.rsp_rdata_o); end
      n_chk++; if (bus.req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL full_pop_nopush got=%b exp=0000", bus.req_ready_o); end
      step();
      bus.l2_rsp_valid_i = 1'b0;
      settle();
      n_chk++; if (bus.req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL full_fifth got=%b exp=0001", bus.req_ready_o); end
      step();
      bus.req_valid_i    = 4'h0;
      bus.l2_rsp_valid_i = 1'b1;
      for (int i = 0; i < MO; i++) begin
         settle();
         n_chk++; if (bus.rsp_valid_o !== 4'b0001) begin n_fail++; $display("FAIL full_drain%0d got=%b exp=0001", i, bus.rsp_valid_o); end
         step();
      end
      bus.l2_rsp_valid_i = 1'b0;
      settle();
      n_chk++; if (bus.rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL full_err got=%b exp=0", bus.rsp_err_o); end
      idle_inputs();
   endtask

   task automatic test_rsp_routing();
      do_reset();
      bus.l2_ready_i  = 1'b1;
      bus.req_last_i  = 4'hF;
      bus.req_valid_i = 4'b0100;
      settle();
      n_chk++; if (bus.req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL route_t2 got=%b exp=0100", bus.req_ready_o); end
      step();
      bus.req_valid_i = 4'b0001;
      settle();
      n_chk++; if (bus.req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL route_t0 got=%b exp=0001", bus.req_ready_o); end
      step();
      bus.req_valid_i = 4'b0010;
      settle();
      n_chk++; if (bus.req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL route_t1 got=%b exp=0010", bus.req_ready_o); end
      step();
      bus.req_valid_i    = 4'h0;
      bus.l2_rsp_valid_i = 1'b1;
      bus.l2_rsp_rdata_i = 32'hA;
      settle();
      n_chk++; if (bus.rsp_valid_o !== 4'b0100 || bus.rsp_rdata_o !== 32'hA) begin n_fail++; $display("FAIL route_rA got=%b/%h exp=0100/0000000a", bus.rsp_valid_o, bus.rsp_rdata_o); end
      step();
      bus.l2_rsp_rdata_i = 32'hB;
      settle();
      n_chk++; if (bus.rsp_valid_o !== 4'b0001 || bus.rsp_rdata_o !== 32'hB) begin n_fail++; $display("FAIL route_rB got=%b/%h exp=0001/0000000b", bus.rsp_valid_o, bus.rsp_rdata_o); end
      step();
      bus.l2_rsp_rdata_i = 32'hC;
      settle();
      n_chk++; if (bus.rsp_valid_o !== 4'b0010 || bus.rsp_rdata_o !== 32'hC) begin n_fail++; $display("FAIL route_rC got=%b/%h exp=0010/0000000c", bus.rsp_valid_o, bus.rsp_rdata_o); end
      step();
      bus.l2_rsp_valid_i = 1'b0;
      settle();
      n_chk++; if (bus.rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL route_err got=%b exp=0", bus.rsp_err_o); end
      idle_inputs();
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      bus.l2_ready_i  = 1'b1;
      bus.req_valid_i = 4'b0010;
      step();
      step();
      settle();
      n_chk++; if (bus.req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL mid_locked got=%b exp=0010", bus.req_ready_o); end
      rst = 1'b1;
      #1;
      n_chk++; if (bus.req_ready_o !== 4'b0000 || bus.l2_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_async got=%b/%b exp=0000/0", bus.req_ready_o, bus.l2_valid_o); end
      step();
      rst = 1'b0;
      bus.req_valid_i = 4'hF;
      bus.l2_ready_i  = 1'b0;
      settle();
      n_chk++; if (bus.l2_addr_o !== 32'h1000) begin n_fail++; $display("FAIL mid_unlocked got=%h exp=00001000", bus.l2_addr_o); end
      bus.req_valid_i    = 4'h0;
      bus.l2_rsp_valid_i = 1'b1;
      settle();
      n_chk++; if (bus.rsp_valid_o !== 4'b0000 || bus.rsp_err_o !== 1'b0) begin n_fail++; $display("FAIL mid_rsp got=%b/%b exp=0000/0", bus.rsp_valid_o, bus.rsp_err_o); end
      step();
      bus.l2_rsp_valid_i = 1'b0;
      settle();
      n_chk++; if (bus.rsp_err_o !== 1'b1) begin n_fail++; $display("FAIL mid_err got=%b exp=1", bus.rsp_err_o); end
      step();
      step();
      n_chk++; if (bus.rsp_err_o !== 1'b1) begin n_fail++; $display("FAIL mid_err_sticky got=%b exp=1", bus.rsp_err_o); end
      idle_inputs();
   endtask

`ifdef MESH_L2_ARB_PERF_EN
   task automatic test_perf();
      do_reset();
      bus.l2_ready_i  = 1'b1;
      bus.req_valid_i = 4'b1001;
      step();
      bus.req_valid_i = 4'b1000;
      for (int i = 0; i < 4; i++) step();
      bus.req_valid_i = 4'h0;
      settle();
      n_chk++; if (bus.stall_cnt_o[3] !== 32'd5) begin n_fail++; $display("FAIL perf_t3 got=%0d exp=5", bus.stall_cnt_o[3]); end
      n_chk++; if (bus.stall_cnt_o[0] !== 32'd0) begin n_fail++; $display("FAIL perf_t0 got=%0d exp=0", bus.stall_cnt_o[0]); end
      idle_inputs();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_rr_single();
      test_lock_burst();
      test_fifo_full();
      test_rsp_routing();
      test_reset_mid_burst();
`ifdef MESH_L2_ARB_PERF_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mesh_l2_arbiter.md
MESH_L2_ARBITER -- requirements
Module: mesh_l2_arbiter

Interface
REQ-001 Parameters SHALL be:
  - N_REQ, default 4: number of tile requesters.
  - ADDR_W, default 32: address width.
  - DATA_W, default 32: data width.
  - MAX_OUTST, default 4: outstanding-beat FIFO depth, power of 2.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be:
  - clk_i  in  1  clock.
  - rst_i  in  1  async active-high reset.
  - req_valid_i  in  N_REQ  per-tile beat valid.
  - req_ready_o  out  N_REQ  per-tile beat accepted.
  - req_addr_i  in  N_REQ x ADDR_W  beat address.
  - req_we_i  in  N_REQ  1 = write, 0 = read.
  - req_wdata_i  in  N_REQ x DATA_W  write data.
  - req_last_i  in  N_REQ  final beat of burst.
  - l2_valid_o  out  1  shared port beat valid.
  - l2_ready_i  in  1  shared port accept.
  - l2_addr_o  out  ADDR_W  forwarded address.
  - l2_we_o  out  1  forwarded write enable.
  - l2_wdata_o  out  DATA_W  forwarded data.
  - l2_rsp_valid_i  in  1  in-order response, one per accepted beat.
  - l2_rsp_rdata_i  in  DATA_W  response data.
  - rsp_valid_o  out  N_REQ  one-hot routed response.
  - rsp_rdata_o  out  DATA_W  response data broadcast.
  - rsp_err_o  out  1  sticky: response arrived with empty FIFO.

Function
REQ-004 The FSM SHALL have states IDLE and LOCKED.
REQ-005 In IDLE, grant SHALL go combinationally to the first valid requester at or after rr_ptr, modulo N_REQ.
REQ-006 l2_valid_o SHALL equal the granted req_valid_i AND NOT fifo_full; address, we and wdata SHALL mux from the grantee.
REQ-007 req_ready_o[g] SHALL equal l2_ready_i AND NOT fifo_full for grantee g only; it SHALL be 0 for all others.
REQ-008 A beat SHALL be accepted when l2_valid_o and l2_ready_i are both high; the accepted beat SHALL push the grantee index into the FIFO.
REQ-009 In IDLE, an accepted beat with req_last_i=0 SHALL latch owner=g and go to LOCKED.
REQ-010 In IDLE, an accepted beat with req_last_i=1 SHALL set rr_ptr=(g+1) mod N_REQ and stay in IDLE.
REQ-011 In LOCKED, only owner SHALL be granted, regardless of other valids; an owner valid drop SHALL NOT release the lock.
REQ-012 In LOCKED, an accepted beat with req_last_i=1 SHALL go to IDLE and set rr_ptr=(owner+1) mod N_REQ.
REQ-013 Request path latency SHALL be 0 cycles (combinational); no request-side registers.
REQ-014 On l2_rsp_valid_i with FIFO non-empty, rsp_valid_o SHALL be one-hot at the FIFO head index in the same cycle, and the head SHALL pop.
REQ-015 On l2_rsp_valid_i with FIFO empty, rsp_valid_o SHALL stay 0 and rsp_err_o SHALL set until reset.
REQ-016 A simultaneous push and pop SHALL leave the count unchanged; pointers SHALL wrap modulo MAX_OUTST.
REQ-017 When full, no push SHALL be allowed even if a pop occurs in the same cycle.
REQ-018 With no valid requester in IDLE, l2_valid_o SHALL be 0 and rr_ptr SHALL hold.
REQ-019 Behaviour with N_REQ=1 SHALL degenerate to pass-through plus the FIFO.

Reset
REQ-020 rst_i SHALL force the following state immediately, independent of clk_i:
  - FSM = IDLE, rr_ptr = 0, owner = 0.
  - FIFO empty, rsp_err_o = 0, perf counters = 0.
REQ-021 Reset mid-burst SHALL drop the lock and discard in-flight FIFO entries.
REQ-022 During reset all outputs SHALL be 0 except where they follow combinationally from inputs; req_ready_o and l2_valid_o SHALL be 0 while rst_i is high.

Configuration
REQ-023 Macro MESH_L2_ARB_PERF_EN, when defined, SHALL add output stall_cnt_o (N_REQ x 32).
  - Each entry increments per cycle req_valid_i[k] is high and req_ready_o[k] is low.
  - Each entry saturates at 0xFFFFFFFF.
REQ-024 When the macro is undefined, the port and counters SHALL be absent and function SHALL be otherwise identical.

Verification
REQ-025 Tiles 0 and 2 assert single-beat reads, l2_ready_i=1, rr_ptr=0 -> tile 0 granted in cycle 0, tile 2 in cycle 1, rr_ptr=3 afterwards.
REQ-026 Tile 1 issues a 4-beat write while tile 3 is valid throughout -> all 4 tile 1 beats forwarded contiguously, then tile 3; rr_ptr=2 after tile 1's last beat.
REQ-027 MAX_OUTST=4, l2_rsp_valid_i held 0, tile 0 streams beats -> exactly 4 accepted, then req_ready_o[0]=0; one response -> head routed to rsp_valid_o[0], fifth beat accepted next cycle.
REQ-028 Interleaved beats from tiles 2, 0, 1, then 3 responses with rdata 0xA, 0xB, 0xC -> rsp_valid_o one-hot 4, 1, 2 in that order with matching data.
REQ-029 rst_i pulsed while tile 1 is LOCKED mid-burst with 2 beats outstanding, then one l2_rsp_valid_i -> IDLE, rr_ptr=0, no rsp_valid_o, rsp_err_o=1.
REQ-030 With MESH_L2_ARB_PERF_EN defined, tile 3 held valid for 5 cycles behind tile 0's lock -> stall_cnt_o[3]=5.
